// File: rtl/la_trigger_capture_pkg.sv
// ---------------------------------------------------------------------------
// la_trigger_capture_pkg
// Shared definitions for the logic-analyzer acquisition front end and the
// display generator downstream of it: FSM state encoding and the default
// sample period / capture width.
// ---------------------------------------------------------------------------
package la_trigger_capture_pkg;

  // Defaults shared with the trace display generator.
  localparam int LA_DIV_DEFAULT  = 125;  // 200 kHz sample rate at 25 MHz
  localparam int LA_COLS_DEFAULT = 80;   // display columns per capture

  // Prescaler width; covers the full legal DIV range of 2..255.
  localparam int LA_PRE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    FIRST     = 2'd2,
    SECOND    = 2'd3
  } la_state_t;

endpackage

// File: rtl/la_sync.sv
// ---------------------------------------------------------------------------
// la_sync
// W-wide two-flop synchronizer for the asynchronous probe inputs.
// Ports:
//   clk  in   1  system clock
//   rst  in   1  asynchronous active-high reset (clears both stages)
//   d    in   W  asynchronous inputs
//   q    out  W  synchronized outputs, two clk cycles after d
// ---------------------------------------------------------------------------
module la_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/la_trigger_capture.sv
// ---------------------------------------------------------------------------
// la_trigger_capture
// Acquisition front end of the four-trace logic analyzer. Synchronizes the
// probes, waits for an armed trigger, samples every DIV clocks and writes
// two samples per channel into each display column.
//
// State table:
//   IDLE      | no capture in progress; waits for arm_tick
//   WAIT_TRIG | armed, watching trig_ch for the selected edge
//   FIRST     | waiting for the tick that takes the older sample of a column
//   SECOND    | waiting for the tick that takes the newer sample and writes
//
// Ports:
//   clk        in   1      system clock
//   rst        in   1      asynchronous active-high reset
//   arm_tick   in   1      start / restart a capture (one-cycle pulse)
//   trig_en    in   1      1 = wait for trigger edge, 0 = start on arm
//   trig_ch    in   2      channel watched for the trigger
//   trig_edge  in   1      0 = rising, 1 = falling
//   probe      in   NCH    asynchronous probe inputs
//   we         out  1      display RAM write strobe, one cycle per column
//   waddr      out  AW     column being written
//   wdata      out  2*NCH  {older, newer} sample pair per channel
//   busy       out  1      high while not IDLE
//   done       out  1      pulse coincident with the last we
// ---------------------------------------------------------------------------
module la_trigger_capture
  import la_trigger_capture_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int DIV  = LA_DIV_DEFAULT,
  parameter int COLS = LA_COLS_DEFAULT,
  parameter int AW   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm_tick,
  input  logic             trig_en,
  input  logic [1:0]       trig_ch,
  input  logic             trig_edge,
  input  logic [NCH-1:0]   probe,
  output logic             we,
  output logic [AW-1:0]    waddr,
  output logic [2*NCH-1:0] wdata,
  output logic             busy,
  output logic             done
);

  la_state_t state, state_n;

  logic [NCH-1:0]      sync;
  logic [NCH-1:0]      sync_d;
  logic [NCH-1:0]      older;
  logic [NCH-1:0]      older_n;
  logic [LA_PRE_W-1:0] pre_cnt;
  logic                tick;
  logic                clr_pre;
  logic                rise;
  logic                fall;
  logic                edge_hit;
  logic [AW-1:0]       col;
  logic [AW-1:0]       col_n;
  logic [AW-1:0]       waddr_n;
  logic [2*NCH-1:0]    wdata_n;
  logic                we_n;
  logic                done_n;

  la_sync #(.W(NCH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (probe),
    .q   (sync)
  );

  // sync_d is deliberately left running while idle so that an edge already
  // in flight on the first WAIT_TRIG cycle is still seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_d <= '0;
    else     sync_d <= sync;
  end

  assign rise     = sync[trig_ch] & ~sync_d[trig_ch];
  assign fall     = ~sync[trig_ch] & sync_d[trig_ch];
  assign edge_hit = trig_edge ? fall : rise;

  // Free-running prescaler; realigned only when a capture (re)enters FIRST
  // so the sample grid starts at a fixed offset from the trigger.
  assign tick = (pre_cnt == LA_PRE_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pre_cnt <= '0;
    else if (clr_pre) pre_cnt <= '0;
    else if (tick)    pre_cnt <= '0;
    else              pre_cnt <= pre_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      older <= '0;
      we    <= 1'b0;
      done  <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      older <= older_n;
      we    <= we_n;
      done  <= done_n;
      waddr <= waddr_n;
      wdata <= wdata_n;
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    older_n = older;
    clr_pre = 1'b0;
    we_n    = 1'b0;
    done_n  = 1'b0;
    waddr_n = waddr;
    wdata_n = wdata;

    // arm_tick wins over everything, including a tick in SECOND: a restart
    // never emits the column that was in progress.
    if (arm_tick) begin
      col_n = '0;
      if (trig_en) begin
        state_n = WAIT_TRIG;
      end else begin
        state_n = FIRST;
        clr_pre = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
        end
        WAIT_TRIG: begin
          if (edge_hit) begin
            state_n = FIRST;
            clr_pre = 1'b1;
          end
        end
        FIRST: begin
          if (tick) begin
            older_n = sync;
            state_n = SECOND;
          end
        end
        SECOND: begin
          if (tick) begin
            we_n    = 1'b1;
            waddr_n = col;
            for (int i = 0; i < NCH; i++) begin
              wdata_n[2*i+1] = older[i];
              wdata_n[2*i]   = sync[i];
            end
            if (col == AW'(COLS - 1)) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              col_n   = col + AW'(1);
              state_n = FIRST;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_la_trigger_capture.sv
// ---------------------------------------------------------------------------
// tb_la_trigger_capture
// Self-checking bench for la_trigger_capture with DIV=4, COLS=4. Expected
// columns are queued when a capture is armed and compared as each we strobe
// appears; multi-cycle corner cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_la_trigger_capture;

  localparam int NCH  = 4;
  localparam int DIV  = 4;
  localparam int COLS = 4;
  localparam int AW   = 7;

  logic           clk = 1'b0;
  logic           rst;
  logic           arm_tick;
  logic           trig_en;
  logic [1:0]     trig_ch;
  logic           trig_edge;
  logic [NCH-1:0] probe;
  logic [NCH-1:0] probe_base;
  logic           tog;
  logic           tog_en;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [7:0]     wdata;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  assign probe = probe_base ^ {3'b000, tog};

  la_trigger_capture #(
    .NCH  (NCH),
    .DIV  (DIV),
    .COLS (COLS),
    .AW   (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm_tick  (arm_tick),
    .trig_en   (trig_en),
    .trig_ch   (trig_ch),
    .trig_edge (trig_edge),
    .probe     (probe),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic [7:0]    mask;
    logic          done;
    logic          alt;
  } exp_t;

  typedef struct {
    logic [3:0] probe;
    logic [7:0] wdata;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[5];

  int checks       = 0;
  int errors       = 0;
  int cyc          = 0;
  int we_cnt       = 0;
  int first_we_cyc = -1;
  int tcnt         = 0;
  bit done_seen    = 1'b0;

  always @(posedge clk) cyc++;

  // Probe[0] toggler for the alternating-sample case.
  always @(posedge clk) begin
    #1;
    if (tog_en) begin
      tcnt++;
      if (tcnt == 4) begin
        tcnt = 0;
        tog  = ~tog;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (we === 1'b1) begin
      we_cnt++;
      if (first_we_cyc < 0) first_we_cyc = cyc;
      if (done === 1'b1) done_seen = 1'b1;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we actual waddr=%0d wdata=%0h required no strobe (t=%0t)",
                 waddr, wdata, $time);
      end else begin
        e = sbq.pop_front();
        chk("waddr", 32'(waddr), 32'(e.waddr));
        chk("wdata", 32'(wdata & e.mask), 32'(e.wdata));
        chk("done_with_we", 32'(done), 32'(e.done));
        if (e.alt) chk("alt_sample", 32'(wdata[1] ^ wdata[0]), 32'd1);
      end
    end else if (done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_without_we actual done=1 required done=0 (t=%0t)", $time);
    end
  end

  task automatic push_capture(input logic [7:0] wd, input logic [7:0] mask, input bit alt);
    exp_t e;
    for (int k = 0; k < COLS; k++) begin
      e.waddr = AW'(k);
      e.wdata = wd;
      e.mask  = mask;
      e.done  = (k == COLS - 1);
      e.alt   = alt;
      sbq.push_back(e);
    end
  endtask

  task automatic arm();
    arm_tick = 1'b1;
    @(posedge clk);
    #1;
    arm_tick = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_done_seen"}, 32'(done_seen), 32'd1);
    @(negedge clk);
    #1;
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_queue_left"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic wait_we(input string name, input int target, input int budget);
    int n = 0;
    while (we_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_we_reached"}, 32'(we_cnt >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int edge_cyc;
    int base;

    rst        = 1'b1;
    arm_tick   = 1'b0;
    trig_en    = 1'b0;
    trig_ch    = 2'd0;
    trig_edge  = 1'b0;
    probe_base = '0;
    tog        = 1'b0;
    tog_en     = 1'b0;

    vecs[0] = '{probe: 4'b1010, wdata: 8'hCC};
    vecs[1] = '{probe: 4'b0101, wdata: 8'h33};
    vecs[2] = '{probe: 4'b1111, wdata: 8'hFF};
    vecs[3] = '{probe: 4'b0000, wdata: 8'h00};
    vecs[4] = '{probe: 4'b0110, wdata: 8'h3C};

    settle(3);
    chk("rst_we",    32'(we),    32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    rst = 1'b0;
    settle(2);

    // Immediate captures with constant probe patterns.
    for (int v = 0; v < 5; v++) begin
      probe_base = vecs[v].probe;
      settle(4);
      done_seen = 1'b0;
      push_capture(vecs[v].wdata, 8'hFF, 1'b0);
      arm();
      wait_done("table", 120);
    end

    // Rising-edge trigger on channel 2, latency from the probe edge.
    trig_en    = 1'b1;
    trig_ch    = 2'd2;
    trig_edge  = 1'b0;
    probe_base = 4'b0000;
    settle(4);
    done_seen    = 1'b0;
    first_we_cyc = -1;
    arm();
    settle(9);
    chk("t2_busy_waiting", 32'(busy), 32'd1);
    edge_cyc   = cyc;
    probe_base = 4'b0100;
    push_capture(8'h30, 8'hFF, 1'b0);
    wait_done("t2", 120);
    chk("t2_first_we_latency", 32'(first_we_cyc), 32'(edge_cyc + 3 + 2 * DIV));

    // Falling-edge trigger with only a rising edge present: never starts.
    trig_ch    = 2'd1;
    trig_edge  = 1'b1;
    probe_base = 4'b0000;
    settle(4);
    base = we_cnt;
    arm();
    settle(5);
    probe_base = 4'b0010;
    settle(40);
    chk("t3_busy_stuck", 32'(busy), 32'd1);
    chk("t3_no_we", 32'(we_cnt - base), 32'd0);
    rst = 1'b1;
    #1;
    chk("t3_busy_rst", 32'(busy), 32'd0);
    settle(1);
    rst = 1'b0;

    // Probe[0] toggling every DIV cycles: each column holds differing samples.
    trig_en    = 1'b0;
    trig_ch    = 2'd0;
    trig_edge  = 1'b0;
    probe_base = 4'b0000;
    tcnt       = 0;
    tog_en     = 1'b1;
    settle(8);
    done_seen = 1'b0;
    push_capture(8'h00, 8'hFC, 1'b1);
    arm();
    wait_done("t4", 120);
    tog_en = 1'b0;
    settle(2);
    tog = 1'b0;

    // Re-arm after two columns: restart from column 0 with four full strobes.
    probe_base = 4'b1010;
    settle(4);
    done_seen = 1'b0;
    push_capture(8'hCC, 8'hFF, 1'b0);
    arm();
    wait_we("t5_pre", we_cnt + 2, 60);
    sbq.delete();
    push_capture(8'hCC, 8'hFF, 1'b0);
    base = we_cnt;
    arm();
    wait_done("t5", 120);
    chk("t5_we_after_rearm", 32'(we_cnt - base), 32'd4);

    // Reset while in SECOND, then a clean capture.
    settle(2);
    done_seen = 1'b0;
    push_capture(8'hCC, 8'hFF, 1'b0);
    arm();
    wait_we("t6_pre", we_cnt + 1, 60);
    settle(5);
    chk("t6_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_we_rst",    32'(we),    32'd0);
    chk("t6_done_rst",  32'(done),  32'd0);
    chk("t6_busy_rst",  32'(busy),  32'd0);
    chk("t6_waddr_rst", 32'(waddr), 32'd0);
    sbq.delete();
    settle(1);
    rst = 1'b0;
    settle(4);
    chk("t6_no_done_after_rst", 32'(done_seen), 32'd0);
    push_capture(8'hCC, 8'hFF, 1'b0);
    arm();
    wait_done("t6", 120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
